// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Brief    : Cascaded multi-digit BCD up/down counter with a prescaled step
//            enable, synchronous clear/load, wrap pulse and active-low
//            seven-segment outputs for every digit.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 25000000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  tc,
    output logic                  tick
);

    // Prescaler width; a single-cycle prescale still needs one bit of state.
    localparam int               c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]  c_PMAX = c_PW'(PRESCALE - 1);

    // Active-low segment patterns, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0001100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [c_PW-1:0]       presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  tc_q, tc_d;

    logic                  w_presc_wrap;
    logic [DIGITS:0]       w_carry;      // carry/borrow into digit i; [DIGITS] = full wrap
    logic [4*DIGITS-1:0]   w_step_val;   // value after one step in the current direction
    logic [4*DIGITS-1:0]   w_load_val;   // load value with illegal nibbles forced to 0

    // Prescaler next state: clear wins, otherwise count while enabled.
    always_comb begin
        presc_d      = presc_q;
        w_presc_wrap = en && (presc_q == c_PMAX);
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = w_presc_wrap ? '0 : presc_q + 1'b1;
        end
        // A clear abandons the partial period, including a wrap in the same cycle.
        tick_d = w_presc_wrap && !clr;
    end

    // The step always enters digit 0; each digit passes carry/borrow onward
    // combinationally so all digits settle in the same cycle.
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [3:0] w_cur;
            logic [3:0] w_nxt;
            logic [3:0] w_ld;

            assign w_cur = bcd_q[4*i +: 4];
            assign w_ld  = load_val[4*i +: 4];

            // Per-digit step: wrap at 9 going up, at 0 going down.
            always_comb begin
                w_nxt = w_cur;
                if (w_carry[i]) begin
                    if (up) begin
                        w_nxt = (w_cur >= 4'd9) ? 4'd0 : w_cur + 4'd1;
                    end else begin
                        w_nxt = ((w_cur == 4'd0) || (w_cur > 4'd9)) ? 4'd9 : w_cur - 4'd1;
                    end
                end
            end

            assign w_carry[i+1]       = w_carry[i] && (up ? (w_cur >= 4'd9) : (w_cur == 4'd0));
            assign w_step_val[4*i +: 4] = w_nxt;
            assign w_load_val[4*i +: 4] = (w_ld > 4'd9) ? 4'd0 : w_ld;
            assign hex[7*i +: 7]       = f_seg(bcd_q[4*i +: 4]);
        end
    endgenerate

    // Count next state with priority clear > load > step; tc flags a full wrap.
    always_comb begin
        bcd_d = bcd_q;
        tc_d  = 1'b0;
        if (clr) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d = w_load_val;
        end else if (tick_q) begin
            bcd_d = w_step_val;
            tc_d  = w_carry[DIGITS];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            bcd_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            bcd_q   <= bcd_d;
            tc_q    <= tc_d;
        end
    end

    assign bcd  = bcd_q;
    assign tc   = tc_q;
    assign tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter
// Brief    : Directed self-checking bench for bcd_updown_counter
//            (DIGITS=2, PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        en       = 1'b0;
    logic        up       = 1'b1;
    logic        load     = 1'b0;
    logic [7:0]  load_val = 8'h00;
    logic        clr      = 1'b0;
    logic [7:0]  bcd;
    logic [13:0] hex;
    logic        tc;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int n;
    int tick_cnt;

    bcd_updown_counter #(.DIGITS(2), .PRESCALE(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .bcd      (bcd),
        .hex      (hex),
        .tc       (tc),
        .tick     (tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts falling edges until tick is seen high (bounded).
    task automatic wait_tick(output int cnt);
        cnt = 0;
        while (tick !== 1'b1 && cnt < 20) begin
            @(negedge CLOCK_50);
            cnt++;
        end
    endtask

    function automatic logic [7:0] bcd_of(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge CLOCK_50);
        chk("rst_bcd",  bcd,  8'h00);
        chk("rst_tc",   tc,   1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_hex",  hex,  14'b0000001_0000001);

        // Release and count up
        RESET_N = 1'b1;
        en      = 1'b1;
        up      = 1'b1;
        wait_tick(n);
        chk("first_tick_gap", n, 4);
        @(negedge CLOCK_50);
        chk("up_bcd_1", bcd, 8'h01);
        chk("tick_one_cycle", tick, 1'b0);
        for (int k = 2; k <= 100; k++) begin
            wait_tick(n);
            chk("up_gap", n, 3);
            @(negedge CLOCK_50);
            chk("up_bcd", bcd, bcd_of(k % 100));
            chk("up_tc", tc, (k == 100));
            if (k == 99) chk("hex_99", hex, {7'b0001100, 7'b0001100});
        end
        @(negedge CLOCK_50);
        chk("tc_one_cycle", tc, 1'b0);
        chk("hold_00", bcd, 8'h00);

        // Down wrap, direction change takes effect at the next step
        up = 1'b0;
        wait_tick(n);
        chk("dn_gap", n, 2);
        @(negedge CLOCK_50);
        chk("dn_wrap_bcd", bcd, 8'h99);
        chk("dn_wrap_tc",  tc,  1'b1);
        wait_tick(n);
        chk("dn_gap2", n, 3);
        @(negedge CLOCK_50);
        chk("dn_98_bcd", bcd, 8'h98);
        chk("dn_98_tc",  tc,  1'b0);

        // Load coincident with tick discards the step
        wait_tick(n);
        chk("ld_gap", n, 3);
        load     = 1'b1;
        load_val = 8'h47;
        @(negedge CLOCK_50);
        load = 1'b0;
        chk("ld47_bcd", bcd, 8'h47);
        chk("ld47_tc",  tc,  1'b0);
        chk("ld47_hex", hex, {7'b1001100, 7'b0001111});

        // Clear beats load and restarts the prescale period
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 8'h47;
        @(negedge CLOCK_50);
        clr  = 1'b0;
        load = 1'b0;
        chk("clr_bcd", bcd, 8'h00);
        chk("clr_tc",  tc,  1'b0);
        wait_tick(n);
        chk("clr_gap", n, 4);
        @(negedge CLOCK_50);
        chk("clr_dn_bcd", bcd, 8'h99);
        chk("clr_dn_tc",  tc,  1'b1);

        // Hold with en=0 for 10 cycles, loads still act
        en       = 1'b0;
        tick_cnt = 0;
        load     = 1'b1;
        load_val = 8'h4C;
        @(negedge CLOCK_50);
        load = 1'b0;
        if (tick === 1'b1) tick_cnt++;
        chk("ld4c_bcd", bcd, 8'h40);
        load     = 1'b1;
        load_val = 8'hA3;
        @(negedge CLOCK_50);
        load = 1'b0;
        if (tick === 1'b1) tick_cnt++;
        chk("lda3_bcd", bcd, 8'h03);
        repeat (8) begin
            @(negedge CLOCK_50);
            if (tick === 1'b1) tick_cnt++;
        end
        chk("hold_ticks", tick_cnt, 0);
        chk("hold_bcd",   bcd, 8'h03);
        en = 1'b1;
        wait_tick(n);
        chk("hold_resume_gap", n, 3);
        @(negedge CLOCK_50);
        chk("resume_bcd", bcd, 8'h02);
        chk("resume_tc",  tc,  1'b0);

        // Asynchronous reset mid-count
        load     = 1'b1;
        load_val = 8'h36;
        @(negedge CLOCK_50);
        load = 1'b0;
        chk("ld36_bcd", bcd, 8'h36);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_bcd",  bcd,  8'h00);
        chk("arst_tick", tick, 1'b0);
        chk("arst_tc",   tc,   1'b0);
        chk("arst_hex",  hex,  14'b0000001_0000001);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        wait_tick(n);
        chk("post_rst_gap", n, 4);
        @(negedge CLOCK_50);
        chk("post_rst_bcd", bcd, 8'h99);
        chk("post_rst_tc",  tc,  1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
